sap_1_program_loader: RTL and testbench

SAP_1_PROGRAM_LOADER -- requirements
Module: sap_1_program_loader

---
 rtl/sap_1_pkg.sv | 13 +
 rtl/sap_1_loader_checksum.sv | 16 +
 rtl/sap_1_program_loader.sv | 70 +++++++
 tb/tb_sap_1_program_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_1_pkg.sv
// sap_1_pkg: shared widths and loader FSM encoding for the SAP-1 program loader
// CHECK exists only when SAP_1_LOADER_CHECKSUM_EN is defined.
package sap_1_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DONE = 2'd2;
`ifdef SAP_1_LOADER_CHECKSUM_EN
  localparam state_t CHECK = 2'd3;
`endif
endpackage

// File: rtl/sap_1_loader_checksum.sv
// sap_1_loader_checksum: modulo-256 running sum of the bytes written in a load session
module sap_1_loader_checksum
  import sap_1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sum
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (clr) sum <= '0;
    else if (add) sum <= sum + data;
endmodule

// File: rtl/sap_1_program_loader.sv
// sap_1_program_loader: streams host bytes into external SAP-1 RAM over a valid/ready handshake
// Define SAP_1_LOADER_CHECKSUM_EN to accept and verify a trailing checksum byte.
module sap_1_program_loader
  import sap_1_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDRESS = 4'hF
) (
  input  logic              Clk,
  input  logic              CLRbar,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done,
  output logic              checksum_error
);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic go, load_xfer, last;
  assign go = start && (state == IDLE || state == DONE);
  assign load_xfer = state == LOAD && data_valid;
  assign last = load_xfer && cnt == LAST_ADDRESS;
`ifdef SAP_1_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic check_xfer;
  assign check_xfer = state == CHECK && data_valid;
  assign data_ready = state == LOAD || state == CHECK;
  always_comb state_n = go ? LOAD : last ? CHECK : check_xfer ? DONE : state;
  sap_1_loader_checksum u_checksum (
    .clk  (Clk),
    .rst_n(CLRbar),
    .clr  (go),
    .add  (load_xfer),
    .data (data_in),
    .sum  (sum)
  );
  always_ff @(posedge Clk or negedge CLRbar)
    if (!CLRbar) checksum_error <= 1'b0;
    else if (go) checksum_error <= 1'b0;
    else if (check_xfer) checksum_error <= data_in != sum;
`else
  assign data_ready = state == LOAD;
  always_comb state_n = go ? LOAD : last ? DONE : state;
  assign checksum_error = 1'b0;
`endif
  // the write port is registered, so the last write lands one cycle after LOAD is left
  always_ff @(posedge Clk or negedge CLRbar)
    if (!CLRbar) begin
      state <= IDLE;
      cnt <= '0;
      ram_we <= 1'b0;
      ram_address <= '0;
      ram_data <= '0;
    end else begin
      state <= state_n;
      ram_we <= load_xfer;
      if (go) cnt <= '0;
      else if (load_xfer) cnt <= cnt + 1'b1;
      if (load_xfer) begin
        ram_address <= cnt;
        ram_data <= data_in;
      end
    end
  assign busy = data_ready || ram_we;
  assign done = state == DONE;
endmodule

// File: tb/tb_sap_1_program_loader.sv
// tb_sap_1_program_loader: scoreboard bench for the loader (default and LAST_ADDRESS=3 instances)
module tb_sap_1_program_loader;
  logic Clk = 1'b0, CLRbar = 1'b0, start = 1'b0, start3 = 1'b0, data_valid = 1'b0, valid3 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic data_ready, ram_we, busy, done, checksum_error;
  logic [3:0] ram_address;
  logic [7:0] ram_data;
  logic data_ready3, ram_we3, busy3, done3, checksum_error3;
  logic [3:0] ram_address3;
  logic [7:0] ram_data3;
  int total = 0, bad = 0, wr0 = 0, wr3 = 0, w;
  logic [11:0] q0[$], q3[$];
  logic [3:0] ea0 = 4'h0, ea3 = 4'h0;
  logic [7:0] sm0 = 8'h00, sm3 = 8'h00;

  sap_1_program_loader dut (
    .Clk(Clk), .CLRbar(CLRbar), .start(start), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ram_we(ram_we), .ram_address(ram_address), .ram_data(ram_data),
    .busy(busy), .done(done), .checksum_error(checksum_error)
  );

  sap_1_program_loader #(.LAST_ADDRESS(4'h3)) dut3 (
    .Clk(Clk), .CLRbar(CLRbar), .start(start3), .data_in(data_in), .data_valid(valid3),
    .data_ready(data_ready3), .ram_we(ram_we3), .ram_address(ram_address3), .ram_data(ram_data3),
    .busy(busy3), .done(done3), .checksum_error(checksum_error3)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (ram_we) begin
      wr0++;
      if (q0.size() == 0) chk("we_unexpected", ram_we, 0);
      else begin
        chk("wr_addr", ram_address, q0[0][11:8]);
        chk("wr_data", ram_data, q0[0][7:0]);
        q0.delete(0);
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    if (ram_we3) begin
      wr3++;
      if (q3.size() == 0) chk("we3_unexpected", ram_we3, 0);
      else begin
        chk("wr3_addr", ram_address3, q3[0][11:8]);
        chk("wr3_data", ram_data3, q3[0][7:0]);
        q3.delete(0);
      end
    end
  end

  task automatic begin_session(input bit s);
    @(negedge Clk);
    data_valid = 1'b0;
    valid3 = 1'b0;
    if (s) start3 = 1'b1; else start = 1'b1;
    @(posedge Clk);
    if (s) begin ea3 = 4'h0; sm3 = 8'h00; end else begin ea0 = 4'h0; sm0 = 8'h00; end
    #1;
    chk(s ? "ready3_after_start" : "ready_after_start", s ? data_ready3 : data_ready, 1);
    chk(s ? "busy3_after_start" : "busy_after_start", s ? busy3 : busy, 1);
    chk(s ? "done3_after_start" : "done_after_start", s ? done3 : done, 0);
  endtask

  task automatic send(input bit s, input logic [7:0] b, input logic st = 1'b0);
    @(negedge Clk);
    data_in = b;
    if (s) begin valid3 = 1'b1; start3 = st; end else begin data_valid = 1'b1; start = st; end
    @(posedge Clk);
    if (s) begin q3.push_back({ea3, b}); ea3++; sm3 += b; end
    else begin q0.push_back({ea0, b}); ea0++; sm0 += b; end
  endtask

`ifdef SAP_1_LOADER_CHECKSUM_EN
  task automatic send_chk(input bit s, input logic [7:0] b, input logic st = 1'b0);
    @(negedge Clk);
    data_in = b;
    if (s) begin valid3 = 1'b1; start3 = st; end else begin data_valid = 1'b1; start = st; end
    @(posedge Clk);
  endtask
`endif

  task automatic idle(input int n);
    @(negedge Clk);
    data_valid = 1'b0;
    valid3 = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic reset_dut();
    @(negedge Clk);
    CLRbar = 1'b0;
    data_valid = 1'b0;
    valid3 = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    @(negedge Clk);
    CLRbar = 1'b1;
  endtask

  task automatic finish0();
`ifdef SAP_1_LOADER_CHECKSUM_EN
    send_chk(0, sm0);
    idle(1);
    chk("finish_chk_err", checksum_error, 0);
`else
    idle(1);
`endif
    chk("finish_done", done, 1);
    chk("finish_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk("rst_ready", data_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", checksum_error, 0);
    @(negedge Clk);
    CLRbar = 1'b1;

    // full back-to-back load of 0x00..0x0F
    begin_session(0);
    w = wr0;
    for (int i = 0; i < 16; i++) send(0, 8'(i));
    #2;
    chk("busy_final_we", busy, 1);
`ifdef SAP_1_LOADER_CHECKSUM_EN
    chk("done_in_check", done, 0);
    chk("ready_in_check", data_ready, 1);
    send_chk(0, 8'h78);
    idle(1);
    chk("full_chk_err", checksum_error, 0);
`else
    chk("done_at_final_we", done, 1);
    idle(1);
`endif
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);
    chk("full_ready", data_ready, 0);
    chk("full_writes", wr0 - w, 16);

    // bubbles: valid 1,0,0,1
    begin_session(0);
    w = wr0;
    send(0, 8'h00);
    idle(2);
    chk("bubble_ready", data_ready, 1);
    chk("bubble_no_we", ram_we, 0);
    send(0, 8'h01);
    idle(1);
    chk("bubble_writes", wr0 - w, 2);
    chk("bubble_last_addr", ram_address, 1);
    reset_dut();

    // reset in the middle of a load
    begin_session(0);
    for (int i = 0; i < 5; i++) send(0, 8'($urandom));
    #2 CLRbar = 1'b0;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_addr", ram_address, 0);
    chk("midrst_data", ram_data, 0);
    chk("midrst_ready", data_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", checksum_error, 0);
    @(negedge Clk);
    CLRbar = 1'b1;
    begin_session(0);
    send(0, 8'hAA);
    idle(1);
    chk("restart_addr", ram_address, 0);
    chk("restart_data", ram_data, 8'hAA);
    reset_dut();

    // start pulsed at transfer 7 is ignored
    begin_session(0);
    for (int i = 0; i < 16; i++) send(0, 8'($urandom), i == 7);
    finish0();

`ifdef SAP_1_LOADER_CHECKSUM_EN
    begin_session(0);
    for (int i = 0; i < 16; i++) send(0, 8'h11);
    send_chk(0, 8'h10);
    idle(1);
    chk("chk_good_err", checksum_error, 0);
    chk("chk_good_done", done, 1);
    begin_session(0);
    for (int i = 0; i < 16; i++) send(0, 8'h11);
    send_chk(0, 8'h00);
    idle(1);
    chk("chk_bad_err", checksum_error, 1);
    chk("chk_bad_done", done, 1);
    begin_session(0);
    chk("chk_err_cleared", checksum_error, 0);
    reset_dut();
`endif

    // LAST_ADDRESS=3; a start coinciding with DONE entry must not be seen
    begin_session(1);
    w = wr3;
`ifdef SAP_1_LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send(1, 8'(8'hC0 + i));
    send_chk(1, sm3, 1'b1);
`else
    for (int i = 0; i < 4; i++) send(1, 8'(8'hC0 + i), i == 3);
`endif
    idle(1);
    chk("last3_done", done3, 1);
    chk("last3_ready", data_ready3, 0);
    chk("last3_busy", busy3, 0);
    chk("last3_writes", wr3 - w, 4);
    chk("last3_addr", ram_address3, 3);
    chk("last3_err", checksum_error3, 0);

    idle(2);
    chk("q0_drained", q0.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
